// File: rtl/vedic_seq16_ctrl.sv
// vedic_seq16_ctrl
//   Sequences a 16x16 unsigned multiply through one shared 8x8 Vedic multiplier.
//   After an operand pair is accepted, four partial products are issued on
//   consecutive cycles ({aL,bL}, {aH,bL}, {aL,bH}, {aH,bH}). Each returning
//   mul_p is shifted into place and accumulated. The 32-bit product is held
//   on the output until the consumer takes it.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair offered
//   in_ready   operands accepted this cycle (IDLE only)
//   a, b       16-bit unsigned operands
//   mul_a      8-bit operand to the shared multiplier (0 outside issue cycles)
//   mul_b      8-bit operand to the shared multiplier (0 outside issue cycles)
//   mul_p      16-bit multiplier result, valid MUL_LAT cycles after issue
//   out_valid  product available
//   out_ready  consumer takes product
//   product    32-bit a*b
//   busy       high in every state except IDLE
module vedic_seq16_ctrl #(
   parameter int MUL_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [7:0]  mul_a,
   output logic [7:0]  mul_b,
   input  logic [15:0] mul_p,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] product,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t       state;
   state_t       state_nxt;
   logic [15:0]  a_q;
   logic [15:0]  b_q;
   logic [1:0]   iss_cnt;
   logic [31:0]  acc;
   logic [31:0]  term;
   logic [31:0]  acc_sum;
   logic         accept;
   logic         issuing;
   logic         last_ret;

   // Issue tags travel alongside the multiplier pipeline, so each returning
   // mul_p arrives with its slot index and knows its shift amount.
   logic [MUL_LAT-1:0] tag_vld;
   logic [1:0]         tag_idx [MUL_LAT];

   assign accept   = in_valid && (state == IDLE);
   assign issuing  = (state == ISSUE);
   assign last_ret = tag_vld[MUL_LAT-1] && (tag_idx[MUL_LAT-1] == 2'd3);

   always_comb begin
      term = '0;
      case (tag_idx[MUL_LAT-1])
         2'd0:    term = {16'h0000, mul_p};
         2'd1,
         2'd2:    term = {8'h00, mul_p, 8'h00};
         default: term = {mul_p, 16'h0000};
      endcase
      acc_sum = tag_vld[MUL_LAT-1] ? (acc + term) : acc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b1;
      out_valid = 1'b0;
      mul_a     = '0;
      mul_b     = '0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            case (iss_cnt)
               2'd0:    begin mul_a = a_q[7:0];  mul_b = b_q[7:0];  end
               2'd1:    begin mul_a = a_q[15:8]; mul_b = b_q[7:0];  end
               2'd2:    begin mul_a = a_q[7:0];  mul_b = b_q[15:8]; end
               default: begin mul_a = a_q[15:8]; mul_b = b_q[15:8]; end
            endcase
            if (iss_cnt == 2'd3) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (last_ret) begin
               state_nxt = DONE;
            end
         end
         default: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         iss_cnt <= '0;
         acc     <= '0;
         product <= '0;
         tag_vld <= '0;
         for (int unsigned i = 0; i < MUL_LAT; i++) begin
            tag_idx[i] <= '0;
         end
      end else begin
         if (accept) begin
            a_q     <= a;
            b_q     <= b;
            iss_cnt <= '0;
            acc     <= '0;
         end else begin
            acc <= acc_sum;
            if (issuing) begin
               iss_cnt <= iss_cnt + 2'd1;
            end
         end
         tag_vld[0] <= issuing;
         tag_idx[0] <= iss_cnt;
         for (int unsigned i = 1; i < MUL_LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_idx[i] <= tag_idx[i-1];
         end
         // product is only loaded when the final term lands, so it stays
         // stable through DONE and keeps its value after the handshake.
         if (last_ret) begin
            product <= acc_sum;
         end
      end
   end

endmodule

// File: tb/tb_vedic_seq16_ctrl.sv
// tb_vedic_seq16_ctrl
//   Two controller instances (MUL_LAT=1 and MUL_LAT=3), each with its own
//   pipelined 8x8 multiplier model, share one stimulus stream. Stimulus pushes
//   each accepted operand pair with its a*b into a scoreboard; a negedge
//   monitor tracks each lane's transaction timeline and compares handshakes,
//   issue operands, latency and product.
module tb_vedic_seq16_ctrl;

   localparam int NL = 2;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] a;
   logic [15:0] b;

   logic        in_ready_w  [NL];
   logic        out_valid_w [NL];
   logic        busy_w      [NL];
   logic [7:0]  mul_a_w     [NL];
   logic [7:0]  mul_b_w     [NL];
   logic [15:0] mul_p_w     [NL];
   logic [31:0] product_w   [NL];

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] p;
   } txn_t;

   txn_t sbq [$];

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat(input int g);
      return (g == 0) ? 1 : 3;
   endfunction

   for (genvar g = 0; g < NL; g++) begin : lane
      localparam int L = (g == 0) ? 1 : 3;
      logic [15:0] mpipe [L];

      always @(posedge clk) begin
         mpipe[0] <= 16'(mul_a_w[g]) * 16'(mul_b_w[g]);
         for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
      end
      assign mul_p_w[g] = mpipe[L-1];

      vedic_seq16_ctrl #(.MUL_LAT(L)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready_w[g]),
         .a         (a),
         .b         (b),
         .mul_a     (mul_a_w[g]),
         .mul_b     (mul_b_w[g]),
         .mul_p     (mul_p_w[g]),
         .out_valid (out_valid_w[g]),
         .out_ready (out_ready),
         .product   (product_w[g]),
         .busy      (busy_w[g])
      );
   end

   task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s lane%0d (MUL_LAT=%0d) cyc=%0d: got %h expected %h",
                  name, g, lat(g), cyc, act, exp);
      end
   endtask

   // Reference timeline per lane: accepted at cycle t0, operands issued in
   // cycles t0+1..t0+4, result shown from cycle t0+5+MUL_LAT until taken.
   bit          m_idle [NL] = '{1'b1, 1'b1};
   bit          m_ov   [NL] = '{1'b0, 1'b0};
   int unsigned t0     [NL] = '{0, 0};
   txn_t        cur    [NL];
   logic [31:0] last_p [NL] = '{32'd0, 32'd0};
   int          rd     [NL] = '{0, 0};

   always @(negedge clk) begin
      int unsigned k;
      logic [7:0]  ea;
      logic [7:0]  eb;
      bit          ov;
      for (int g = 0; g < NL; g++) begin
         if (!rst_n) begin
            chk("rst_in_ready",  g, 32'(in_ready_w[g]),  32'd1);
            chk("rst_out_valid", g, 32'(out_valid_w[g]), 32'd0);
            chk("rst_busy",      g, 32'(busy_w[g]),      32'd0);
            chk("rst_product",   g, product_w[g],        32'd0);
            chk("rst_mul_a",     g, 32'(mul_a_w[g]),     32'd0);
            chk("rst_mul_b",     g, 32'(mul_b_w[g]),     32'd0);
            m_idle[g] = 1'b1;
            m_ov[g]   = 1'b0;
            last_p[g] = '0;
         end else begin
            k  = cyc - t0[g];
            ea = '0;
            eb = '0;
            if (!m_idle[g]) begin
               case (k)
                  1: begin ea = cur[g].a[7:0];  eb = cur[g].b[7:0];  end
                  2: begin ea = cur[g].a[15:8]; eb = cur[g].b[7:0];  end
                  3: begin ea = cur[g].a[7:0];  eb = cur[g].b[15:8]; end
                  4: begin ea = cur[g].a[15:8]; eb = cur[g].b[15:8]; end
                  default: ;
               endcase
            end
            ov = !m_idle[g] && (k >= 32'(5 + lat(g)));
            chk("in_ready",  g, 32'(in_ready_w[g]),  32'(m_idle[g]));
            chk("busy",      g, 32'(busy_w[g]),      32'(!m_idle[g]));
            chk("mul_a",     g, 32'(mul_a_w[g]),     32'(ea));
            chk("mul_b",     g, 32'(mul_b_w[g]),     32'(eb));
            chk("out_valid", g, 32'(out_valid_w[g]), 32'(ov));
            if (ov) begin
               chk("product", g, product_w[g], cur[g].p);
            end else if (m_idle[g]) begin
               chk("product_hold", g, product_w[g], last_p[g]);
            end
            if (ov && out_ready) begin
               m_idle[g] = 1'b1;
               last_p[g] = cur[g].p;
            end else if (m_idle[g] && in_valid) begin
               checks++;
               if (rd[g] < sbq.size()) begin
                  cur[g] = sbq[rd[g]];
                  rd[g]++;
               end else begin
                  errors++;
                  $display("FAIL scoreboard_empty lane%0d cyc=%0d: got accept expected none", g, cyc);
               end
               m_idle[g] = 1'b0;
               t0[g]     = cyc;
            end
            m_ov[g] = !m_idle[g] && ((cyc + 1 - t0[g]) >= 32'(5 + lat(g)));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for both lanes to be idle; meanwhile scrambles a/b and, when both
   // lanes are busy, pulses in_valid (which must be ignored).
   task automatic wait_idle(input bit rnd);
      int n;
      n = 0;
      in_valid = 1'b0;
      while (!(m_idle[0] && m_idle[1])) begin
         if (n == 400) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout cyc=%0d: got busy expected idle", cyc);
            return;
         end
         step();
         n++;
         in_valid = 1'b0;
         a = 16'($urandom);
         b = 16'($urandom);
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         if (!m_idle[0] && !m_idle[1] && $urandom_range(0, 3) == 0) in_valid = 1'b1;
      end
   endtask

   task automatic send(input logic [15:0] x, input logic [15:0] y);
      txn_t t;
      t.a = x;
      t.b = y;
      t.p = 32'(x) * 32'(y);
      sbq.push_back(t);
      a = x;
      b = y;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
   endtask

   initial begin
      int n;
      logic [15:0] x;
      logic [15:0] y;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      repeat (3) step();
      rst_n = 1'b1;

      send(16'h1234, 16'h5678); wait_idle(1'b0);
      send(16'hFFFF, 16'hFFFF); wait_idle(1'b0);
      send(16'h0000, 16'hBEEF); wait_idle(1'b0);
      send(16'h00FF, 16'h0100); wait_idle(1'b0);

      // Consumer stalls with the result showing; in_valid pulses are ignored.
      out_ready = 1'b0;
      send(16'hA5C3, 16'h3C5A);
      n = 0;
      while (!(m_ov[0] && m_ov[1]) && n < 100) begin
         step();
         n++;
      end
      if (n == 100) begin
         checks++;
         errors++;
         $display("FAIL out_valid_timeout cyc=%0d: got no result expected result", cyc);
      end
      repeat (5) begin
         in_valid = ~in_valid;
         a = 16'($urandom);
         b = 16'($urandom);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_idle(1'b0);

      // Abort in cycle 3, then a fresh transaction.
      send(16'hBEEF, 16'hCAFE);
      step();
      step();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      send(16'h0F0F, 16'hF00D); wait_idle(1'b0);

      repeat (24) begin
         x = 16'($urandom);
         y = 16'($urandom);
         case ($urandom_range(0, 5))
            0: x = '0;
            1: y = '0;
            2: x[15:8] = '0;
            3: y[7:0] = '1;
            default: ;
         endcase
         send(x, y);
         wait_idle(1'b1);
      end
      out_ready = 1'b1;
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
